// File: rtl/fc_pkg.sv
// fc_pkg: shared types for the fully-connected weight-load path.
// The fc_wr_req_t bundle is sized for the default configuration
// (4 banks of 8 words of 16 bits) so bank arrays can take one port.
package fc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } fc_load_state_t;

    localparam int FC_SIZE   = 2;
    localparam int FC_DEPTH  = 8;
    localparam int FC_ADDR_W = $clog2(FC_DEPTH);
    localparam int FC_DATA_W = 16;

    typedef struct packed {
        logic [FC_SIZE-1:0]   bank_sel;
        logic [FC_ADDR_W-1:0] wr_addr;
        logic [FC_DATA_W-1:0] wr_data;
    } fc_wr_req_t;

endpackage

// File: rtl/fc_wrap_counter.sv
// fc_wrap_counter: W-bit up counter that returns to zero after reaching 'max'.
// 'wrap' flags an increment that is about to roll the counter over, so
// counters can be chained by feeding one's wrap into the next one's inc.
module fc_wrap_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] max,
    output logic [W-1:0] count,
    output logic         wrap
);

    assign wrap = inc && (count == max);

    // Count accepted increments; clear and wrap both return to zero.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count <= '0;
        end else if (wrap) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fc_load_sequencer.sv
// fc_load_sequencer: distributes a valid/ready stream of weight words
// round-robin (bank-first) across NUM_BANKS banks of DEPTH words each.
// Optional input parity checking is enabled with macro FC_LOAD_PARITY_EN.
module fc_load_sequencer
    import fc_pkg::*;
#(
    parameter int SIZE      = 2,
    parameter int NUM_BANKS = 4,
    parameter int DEPTH     = 8,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [SIZE-1:0]   bank_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    output logic              busy,
    output logic              done
`ifdef FC_LOAD_PARITY_EN
    ,
    input  logic              in_par,
    output logic              par_err
`endif
);

    fc_load_state_t    state;
    logic              accept;
    logic              start_accept;
    logic [SIZE-1:0]   bank_cnt;
    logic [ADDR_W-1:0] addr_cnt;
    logic              bank_wrap;
    logic              addr_wrap;

    assign in_ready     = (state == LOAD);
    assign busy         = (state != IDLE);
    assign accept       = in_valid && in_ready;
    assign start_accept = (state == IDLE) && start;

    fc_wrap_counter #(.W(SIZE)) u_bank_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_accept),
        .inc   (accept),
        .max   (SIZE'(NUM_BANKS - 1)),
        .count (bank_cnt),
        .wrap  (bank_wrap)
    );

    // The address only advances when the bank index rolls over, and its own
    // rollover marks the last word of the load.
    fc_wrap_counter #(.W(ADDR_W)) u_addr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_accept),
        .inc   (bank_wrap),
        .max   (ADDR_W'(DEPTH - 1)),
        .count (addr_cnt),
        .wrap  (addr_wrap)
    );

    // Load FSM with registered write request; fields hold between writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            bank_sel <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_en    <= 1'b0;
            done     <= 1'b0;
        end else begin
            wr_en <= accept;
            done  <= 1'b0;
            if (accept) begin
                bank_sel <= bank_cnt;
                wr_addr  <= addr_cnt;
                wr_data  <= in_data;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (addr_wrap) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FC_LOAD_PARITY_EN
    // Sticky even-parity error over accepted words, cleared by a new load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_err <= 1'b0;
        end else if (start_accept) begin
            par_err <= 1'b0;
        end else if (accept && (^{in_data, in_par})) begin
            par_err <= 1'b1;
        end
    end
`endif

endmodule
